// File: rtl/gb_host_bridge.sv
// Host command stream to ghostbus master with command FIFO and read latency.
// Optional burst auto-increment via `define GB_HOST_AUTOINC_EN (adds cmd_len).
module gb_host_bridge #(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int FIFO_AW    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic          gb_clk,
  input  logic          gb_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
`ifdef GB_HOST_AUTOINC_EN
  input  logic [7:0]    cmd_len,
`endif
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_C = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] P_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0] C_ONE = (FIFO_AW+1)'(1);
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

  typedef struct packed {
    logic          wr;
    logic [7:0]    len;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_RSTB  = 3'd2,
    S_RWAIT = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  entry_t mem_q [DEPTH];
  entry_t in_e;
  entry_t head;

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wen_q;
  logic          rstb_q;
  logic [3:0]    lat_q;
  logic [7:0]    beats_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (cnt_q == FULL_C);
  assign empty = (cnt_q == '0);
  assign push  = cmd_valid & ~full;
  assign head  = mem_q[rd_ptr_q];

  // Pack the incoming command into one FIFO entry.
  always_comb begin
    in_e.wr   = cmd_write;
`ifdef GB_HOST_AUTOINC_EN
    in_e.len  = cmd_len;
`else
    in_e.len  = 8'd0;
`endif
    in_e.addr = cmd_addr;
    in_e.data = cmd_wdata;
  end

  // Head is consumed only when the bus is free for a new command.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      S_IDLE:  pop = ~empty;
      S_WRITE: pop = ~empty & (beats_q == 8'd0);
      default: pop = 1'b0;
    endcase
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + P_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + P_ONE;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + C_ONE;
      2'b01:   cnt_d = cnt_q - C_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy guards them.
  always_ff @(posedge gb_clk) begin
    if (push) mem_q[wr_ptr_q] <= in_e;
  end

  // FIFO pointer registers.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Bus sequencer with registered bus and response outputs.
  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      rstb_q      <= 1'b0;
      lat_q       <= '0;
      beats_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_WRITE: begin
          if (beats_q != 8'd0) begin
            addr_q  <= addr_q + A_ONE;
            beats_q <= beats_q - 8'd1;
          end else if (empty) begin
            wen_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RSTB: begin
          rstb_q  <= 1'b0;
          lat_q   <= LAT_INIT;
          state_q <= S_RWAIT;
        end
        S_RWAIT: begin
          if (lat_q == 4'd0) begin
            rsp_rdata_q <= gb_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (beats_q != 8'd0) begin
              addr_q  <= addr_q + A_ONE;
              beats_q <= beats_q - 8'd1;
              rstb_q  <= 1'b1;
              state_q <= S_RSTB;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          wen_q   <= 1'b0;
          rstb_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
      if (pop) begin
        addr_q  <= head.addr;
        beats_q <= head.len;
        if (head.wr) begin
          wdata_q <= head.data;
          wen_q   <= 1'b1;
          rstb_q  <= 1'b0;
          state_q <= S_WRITE;
        end else begin
          wen_q   <= 1'b0;
          rstb_q  <= 1'b1;
          state_q <= S_RSTB;
        end
      end
    end
  end

  assign cmd_ready = ~full;
  assign busy      = ~empty | (state_q != S_IDLE);
  assign gb_addr   = addr_q;
  assign gb_wdata  = wdata_q;
  assign gb_wen    = wen_q;
  assign gb_rstb   = rstb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gb_host_bridge.sv
// Randomized self-checking bench for gb_host_bridge.
// Scoreboard derives expected bus ops and read data from command order.
module tb_gb_host_bridge;

  localparam int AW  = 24;
  localparam int DW  = 32;
  localparam int FA  = 2;
  localparam int RDL = 1;

  logic          gb_clk = 1'b0;
  logic          gb_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [7:0]    cmd_len = 8'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_wen;
  logic          gb_rstb;
  logic [DW-1:0] gb_rdata = '0;

  gb_host_bridge #(
    .AW(AW), .DW(DW), .FIFO_AW(FA), .RD_LATENCY(RDL)
  ) dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
`ifdef GB_HOST_AUTOINC_EN
    .cmd_len(cmd_len),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata),
    .gb_wen(gb_wen), .gb_rstb(gb_rstb),
    .gb_rdata(gb_rdata)
  );

  always #5 gb_clk = ~gb_clk;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int both_hi = 0;
  int stab_err = 0;
  logic stall_q = 1'b0;
  logic [DW-1:0] stall_d = '0;
  bit rnd_on = 1'b0;

  op_t exp_ops[$];
  op_t obs_ops[$];
  int  obs_cyc[$];
  logic [DW-1:0] exp_rsp[$];
  logic [DW-1:0] obs_rsp[$];
  int  rsp_cyc[$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] dev_mem [logic [AW-1:0]];

  always @(posedge gb_clk) cyc <= cyc + 1;

  // Reference: each command expands to len+1 beats at consecutive
  // addresses; reads return the last value written in command order.
  function automatic void model_accept(input logic w,
      input logic [AW-1:0] a, input logic [DW-1:0] d, input int n);
    logic [AW-1:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + AW'(k);
      if (w) begin
        exp_ops.push_back(op_t'{1'b1, ak, d});
        model_mem[ak] = d;
      end else begin
        exp_ops.push_back(op_t'{1'b0, ak, DW'(0)});
        exp_rsp.push_back(model_mem.exists(ak) ? model_mem[ak] : DW'(ak));
      end
    end
  endfunction

  // Monitor plus bus-slave model, sampled mid-cycle.
  always @(negedge gb_clk) begin
    if (gb_rst) begin
      stall_q = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
`ifdef GB_HOST_AUTOINC_EN
        model_accept(cmd_write, cmd_addr, cmd_wdata, int'(cmd_len) + 1);
`else
        model_accept(cmd_write, cmd_addr, cmd_wdata, 1);
`endif
      end
      if (gb_wen) begin
        obs_ops.push_back(op_t'{1'b1, gb_addr, gb_wdata});
        obs_cyc.push_back(cyc);
        dev_mem[gb_addr] = gb_wdata;
      end
      if (gb_rstb) begin
        obs_ops.push_back(op_t'{1'b0, gb_addr, DW'(0)});
        obs_cyc.push_back(cyc);
      end
      if (gb_wen && gb_rstb) both_hi++;
      if (stall_q && (!rsp_valid || rsp_rdata !== stall_d)) stab_err++;
      stall_q = rsp_valid && !rsp_ready;
      stall_d = rsp_rdata;
      if (rsp_valid && rsp_ready) begin
        obs_rsp.push_back(rsp_rdata);
        rsp_cyc.push_back(cyc);
      end
    end
    gb_rdata = dev_mem.exists(gb_addr) ? dev_mem[gb_addr] : DW'(gb_addr);
  end

  task automatic clear_q();
    exp_ops.delete();
    obs_ops.delete();
    obs_cyc.delete();
    exp_rsp.delete();
    obs_rsp.delete();
    rsp_cyc.delete();
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a,
      input logic [DW-1:0] d, input logic [7:0] len);
    int t;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_len   = len;
    cmd_valid = 1'b1;
    t = 0;
    @(negedge gb_clk);
    while (!cmd_ready && t < 300) begin
      @(negedge gb_clk);
      t++;
    end
    if (t >= 300) begin
      checks++;
      $display("FAIL cmd_accept_timeout addr=%h", a);
    end
    @(posedge gb_clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge gb_clk);
    while ((busy || rsp_valid) && t < 1000) begin
      @(negedge gb_clk);
      t++;
    end
    if (t >= 1000) begin
      checks++;
      $display("FAIL drain_timeout busy=%b rsp_valid=%b", busy, rsp_valid);
    end
    repeat (2) @(posedge gb_clk);
    #1;
  endtask

  task automatic test_reset();
    gb_rst = 1'b1;
    repeat (3) @(posedge gb_clk);
    @(negedge gb_clk);
    checks++;
    if ({gb_addr, gb_wdata, gb_wen, gb_rstb} !== '0)
      $display("FAIL reset_bus got %h/%h/%b/%b want 0",
               gb_addr, gb_wdata, gb_wen, gb_rstb);
    else passes++;
    checks++;
    if ({rsp_valid, rsp_rdata, busy} !== '0)
      $display("FAIL reset_rsp got v=%b d=%h busy=%b want 0",
               rsp_valid, rsp_rdata, busy);
    else passes++;
    checks++;
    if (cmd_ready !== 1'b1)
      $display("FAIL reset_ready got %b want 1", cmd_ready);
    else passes++;
    @(posedge gb_clk);
    #1 gb_rst = 1'b0;
  endtask

  task automatic test_single_write();
    clear_q();
    rsp_ready = 1'b1;
    send_cmd(1'b1, 24'h000001, 32'h0000000e, 8'd0);
    cmd_valid = 1'b0;
    repeat (6) @(posedge gb_clk);
    #1;
    checks++;
    if (obs_ops.size() !== 1)
      $display("FAIL wr1_count got %0d want 1", obs_ops.size());
    else passes++;
    checks++;
    if (obs_ops[0] !== op_t'{1'b1, 24'h000001, 32'h0000000e})
      $display("FAIL wr1_op got %h want %h", obs_ops[0],
               op_t'{1'b1, 24'h000001, 32'h0000000e});
    else passes++;
    checks++;
    if (obs_rsp.size() !== 0)
      $display("FAIL wr1_no_rsp got %0d want 0", obs_rsp.size());
    else passes++;
  endtask

  task automatic test_read_latency();
    clear_q();
    rsp_ready = 1'b1;
    send_cmd(1'b0, 24'h000020, 32'h0, 8'd0);
    cmd_valid = 1'b0;
    repeat (8) @(posedge gb_clk);
    #1;
    checks++;
    if (obs_ops.size() !== 1 || obs_ops[0] !== op_t'{1'b0, 24'h20, 32'h0})
      $display("FAIL rd_strobe got n=%0d op=%h want one read @20",
               obs_ops.size(), obs_ops[0]);
    else passes++;
    checks++;
    if (obs_rsp.size() !== 1 || obs_rsp[0] !== 32'h00000020)
      $display("FAIL rd_data got n=%0d d=%h want 00000020",
               obs_rsp.size(), obs_rsp[0]);
    else passes++;
    checks++;
    if (rsp_cyc[0] - obs_cyc[0] !== RDL + 1)
      $display("FAIL rd_latency got %0d want %0d",
               rsp_cyc[0] - obs_cyc[0], RDL + 1);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int rdy_hi;
    int n_stall;
    int hcyc;
    int t;
    logic [DW-1:0] wd [4];
    clear_q();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 24'h000030, 32'h0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      send_cmd(1'b1, AW'(4 + i), wd[i], 8'd0);
    end
    cmd_write = 1'b1;
    cmd_addr  = 24'h000008;
    cmd_wdata = 32'h88;
    cmd_valid = 1'b1;
    rdy_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge gb_clk);
      if (cmd_ready) rdy_hi++;
    end
    n_stall = obs_ops.size();
    checks++;
    if (rdy_hi !== 0)
      $display("FAIL full_ready got %0d ready cycles want 0", rdy_hi);
    else passes++;
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1)
      $display("FAIL stall_state got busy=%b v=%b want 1/1",
               busy, rsp_valid);
    else passes++;
    checks++;
    if (n_stall !== 1)
      $display("FAIL stall_no_wen got %0d ops want 1", n_stall);
    else passes++;
    @(posedge gb_clk);
    #1 rsp_ready = 1'b1;
    @(negedge gb_clk);
    hcyc = cyc;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge gb_clk);
      t++;
    end
    @(posedge gb_clk);
    #1 cmd_valid = 1'b0;
    drain();
    checks++;
    if (stab_err !== 0)
      $display("FAIL rsp_stable got %0d glitches want 0", stab_err);
    else passes++;
    checks++;
    if (obs_ops.size() !== 6)
      $display("FAIL b2b_count got %0d want 6", obs_ops.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_ops[i+1] !== op_t'{1'b1, AW'(4 + i), wd[i]} ||
          obs_cyc[i+1] !== obs_cyc[1] + i)
        $display("FAIL b2b_wr%0d got %h@%0d want %h@%0d", i,
                 obs_ops[i+1], obs_cyc[i+1],
                 op_t'{1'b1, AW'(4 + i), wd[i]}, obs_cyc[1] + i);
      else passes++;
    end
    checks++;
    if (obs_cyc[1] <= hcyc || obs_cyc[1] > hcyc + 2)
      $display("FAIL wr_after_rsp got cyc %0d want %0d..%0d",
               obs_cyc[1], hcyc + 1, hcyc + 2);
    else passes++;
    checks++;
    if (obs_rsp.size() !== 1 || obs_rsp[0] !== exp_rsp[0])
      $display("FAIL stall_rsp got %h want %h", obs_rsp[0], exp_rsp[0]);
    else passes++;
  endtask

  task automatic test_reset_rwait();
    int t;
    clear_q();
    rsp_ready = 1'b1;
    send_cmd(1'b0, 24'h000040, 32'h0, 8'd0);
    cmd_valid = 1'b0;
    t = 0;
    @(negedge gb_clk);
    while (!gb_rstb && t < 20) begin
      @(negedge gb_clk);
      t++;
    end
    checks++;
    if (t >= 20) $display("FAIL rwait_rstb_timeout got none want rstb");
    else passes++;
    @(posedge gb_clk);
    #1 gb_rst = 1'b1;
    @(posedge gb_clk);
    #1 gb_rst = 1'b0;
    @(negedge gb_clk);
    checks++;
    if ({gb_addr, gb_wdata, gb_wen, gb_rstb, rsp_valid} !== '0 ||
        cmd_ready !== 1'b1)
      $display("FAIL rwait_reset got a=%h wen=%b rstb=%b v=%b rdy=%b",
               gb_addr, gb_wen, gb_rstb, rsp_valid, cmd_ready);
    else passes++;
    repeat (20) @(posedge gb_clk);
    #1;
    checks++;
    if (obs_rsp.size() !== 0)
      $display("FAIL rwait_dropped got %0d rsp want 0", obs_rsp.size());
    else passes++;
    clear_q();
  endtask

`ifdef GB_HOST_AUTOINC_EN
  task automatic test_autoinc();
    logic [AW-1:0] ea [4];
    ea[0] = 24'hfffffe;
    ea[1] = 24'hffffff;
    ea[2] = 24'h000000;
    ea[3] = 24'h000001;
    clear_q();
    rsp_ready = 1'b1;
    send_cmd(1'b0, 24'hfffffe, 32'h0, 8'd3);
    send_cmd(1'b1, 24'h000050, 32'hcafe0050, 8'd2);
    cmd_valid = 1'b0;
    cmd_len = 8'd0;
    drain();
    checks++;
    if (obs_ops.size() !== 7 || obs_rsp.size() !== 4)
      $display("FAIL burst_count got %0d ops %0d rsp want 7/4",
               obs_ops.size(), obs_rsp.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_ops[i] !== op_t'{1'b0, ea[i], DW'(0)} ||
          obs_rsp[i] !== exp_rsp[i])
        $display("FAIL burst_rd%0d got %h/%h want @%h/%h", i,
                 obs_ops[i], obs_rsp[i], ea[i], exp_rsp[i]);
      else passes++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_ops[4+i] !== op_t'{1'b1, AW'(24'h50 + i), 32'hcafe0050})
        $display("FAIL burst_wr%0d got %h", i, obs_ops[4+i]);
      else passes++;
    end
    clear_q();
  endtask
`endif

  task automatic test_random();
    logic w;
    logic [AW-1:0] a;
    logic [7:0] len;
    int errs;
    clear_q();
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          w = 1'($urandom % 2);
          a = AW'($urandom % 16);
          len = 8'd0;
`ifdef GB_HOST_AUTOINC_EN
          len = 8'($urandom % 3);
          if ($urandom % 4 == 0) a = 24'hfffff0 + AW'($urandom % 16);
`endif
          send_cmd(w, a, $urandom, len);
          if ($urandom % 3 == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom % 3) @(posedge gb_clk);
            #1;
          end
        end
        cmd_valid = 1'b0;
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge gb_clk);
          #1 rsp_ready = 1'($urandom % 2);
        end
      end
    join
    rsp_ready = 1'b1;
    drain();
    checks++;
    if (obs_ops.size() !== exp_ops.size())
      $display("FAIL rnd_op_count got %0d want %0d",
               obs_ops.size(), exp_ops.size());
    else passes++;
    errs = 0;
    for (int i = 0; i < exp_ops.size(); i++)
      if (obs_ops[i] !== exp_ops[i]) begin
        if (errs < 4)
          $display("FAIL rnd_op%0d got %h want %h", i,
                   obs_ops[i], exp_ops[i]);
        errs++;
      end
    checks++;
    if (errs !== 0) $display("FAIL rnd_ops got %0d bad want 0", errs);
    else passes++;
    checks++;
    if (obs_rsp.size() !== exp_rsp.size())
      $display("FAIL rnd_rsp_count got %0d want %0d",
               obs_rsp.size(), exp_rsp.size());
    else passes++;
    errs = 0;
    for (int i = 0; i < exp_rsp.size(); i++)
      if (obs_rsp[i] !== exp_rsp[i]) begin
        if (errs < 4)
          $display("FAIL rnd_rsp%0d got %h want %h", i,
                   obs_rsp[i], exp_rsp[i]);
        errs++;
      end
    checks++;
    if (errs !== 0) $display("FAIL rnd_rsps got %0d bad want 0", errs);
    else passes++;
    checks++;
    if (both_hi !== 0 || stab_err !== 0)
      $display("FAIL rnd_protocol got both=%0d glitch=%0d want 0/0",
               both_hi, stab_err);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_latency();
    test_back_to_back();
    test_reset_rwait();
`ifdef GB_HOST_AUTOINC_EN
    test_autoinc();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
